// File: rtl/ws_pkg.sv
// ws_pkg: shared inst bit positions, FSM state enum and idle instruction word for the ws_inst_seq slice
package ws_pkg;
    localparam int INST_W        = 40;
    localparam int INST_LOAD     = 0;
    localparam int INST_EXEC     = 1;
    localparam int INST_MODE     = 2;
    localparam int INST_L0_WR    = 3;
    localparam int INST_L0_RD    = 4;
    localparam int INST_IFIFO_RD = 5;
    localparam int INST_IFIFO_WR = 6;
    localparam int INST_OFIFO_RD = 7;
    localparam int INST_A0       = 8;
    localparam int INST_WEN0     = 16;
    localparam int INST_CEN0     = 17;
    localparam int INST_A1       = 18;
    localparam int INST_CEN1     = 26;
    localparam int INST_A_PMEM   = 27;
    localparam int INST_WEN_PMEM = 36;
    localparam int INST_CEN_PMEM = 37;
    localparam int INST_ACC      = 38;
    localparam int INST_BYPASS   = 39;

    typedef enum logic [2:0] {IDLE, LOAD_W, EXEC, FLUSH, DRAIN, WAIT_PS, DONE} ws_state_e;

    function automatic logic [INST_W-1:0] inst_idle();
        logic [INST_W-1:0] w;
        w = '0;
        w[INST_CEN_PMEM] = 1'b1;
        w[INST_WEN_PMEM] = 1'b1;
        w[INST_CEN1] = 1'b1;
        w[INST_CEN0] = 1'b1;
        w[INST_WEN0] = 1'b1;
        return w;
    endfunction
endpackage

// File: rtl/ws_inst_seq_if.sv
// ws_inst_seq_if: sequencer bus (start, l0_ready, ofifo_valid in; inst, busy, done, kij_idx, stall_cnt under WS_SEQ_PERF_EN out) with master/slave modports
interface ws_inst_seq_if;
    import ws_pkg::*;
    logic              start;
    logic              l0_ready;
    logic              ofifo_valid;
    logic [INST_W-1:0] inst;
    logic              busy;
    logic              done;
    logic [3:0]        kij_idx;
`ifdef WS_SEQ_PERF_EN
    logic [15:0]       stall_cnt;
    modport master (input start, l0_ready, ofifo_valid, output inst, busy, done, kij_idx, stall_cnt);
    modport slave (output start, l0_ready, ofifo_valid, input inst, busy, done, kij_idx, stall_cnt);
`else
    modport master (input start, l0_ready, ofifo_valid, output inst, busy, done, kij_idx);
    modport slave (output start, l0_ready, ofifo_valid, input inst, busy, done, kij_idx);
`endif
endinterface

// File: rtl/ws_ctrl_dly.sv
// ws_ctrl_dly: DEPTH-deep 3-bit shift line for mode/execute/load tags; ports clk, reset (sync active-low clear), din, dout
module ws_ctrl_dly #(
    parameter int DEPTH = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] din,
    output logic [2:0] dout
);
    logic [2:0] line [DEPTH];
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) line[i] <= 3'b000;
        end else begin
            line[0] <= din;
            for (int i = 1; i < DEPTH; i++) line[i] <= line[i-1];
        end
    end
    assign dout = line[DEPTH-1];
endmodule

// File: rtl/ws_inst_seq.sv
// ws_inst_seq: weight-stationary instruction sequencer building the registered 40-bit core inst; ports clk, reset (sync active-low), bus (ws_inst_seq_if.master); WS_SEQ_PERF_EN adds bus.stall_cnt
module ws_inst_seq
    import ws_pkg::*;
#(
    parameter int         COL       = 8,
    parameter int         LEN_KIJ   = 9,
    parameter int         LEN_NIJ   = 2,
    parameter logic [7:0] W_BASE    = 8'h80,
    parameter int         W_STRIDE  = 8,
    parameter logic [7:0] X_BASE    = 8'h00,
    parameter int         CTRL_DLY  = 3,
    parameter int         DRAIN_CYC = 19
) (
    input logic           clk,
    input logic           reset,
    ws_inst_seq_if.master bus
);
    localparam logic [7:0] T_LAST = 8'(COL - 1);
    localparam logic [7:0] N_LAST = 8'(LEN_NIJ - 1);
    localparam logic [7:0] D_LAST = 8'(DRAIN_CYC - 1);
    localparam logic [3:0] K_LAST = 4'(LEN_KIJ - 1);
    localparam logic [8:0] P_MAX  = 9'(LEN_KIJ * LEN_NIJ);

    ws_state_e         state, nxt;
    logic [7:0]        t, n, d, addr;
    logic [3:0]        kij;
    logic [8:0]        psum_cnt;
    logic [2:0]        tag, ctrl;
    logic              issue, wr, accept;
    logic [INST_W-1:0] inst_q, inst_d;

    assign accept = state == IDLE && bus.start;
    assign wr = state != IDLE && bus.ofifo_valid;

    always_comb begin
        nxt = state;
        issue = 1'b0;
        addr = 8'h00;
        tag = 3'b000;
        case (state)
            IDLE: nxt = bus.start ? LOAD_W : IDLE;
            LOAD_W: begin
                issue = bus.l0_ready;
                addr = W_BASE + 8'(W_STRIDE * int'(kij)) + t;
                tag = {2'b00, issue};
                nxt = issue && t == T_LAST ? EXEC : LOAD_W;
            end
            EXEC: begin
                issue = bus.l0_ready;
                addr = X_BASE + n;
                tag = {1'b0, issue, 1'b0};
                nxt = issue && n == N_LAST ? FLUSH : EXEC;
            end
            FLUSH: begin
                tag = 3'b111;
                nxt = DRAIN;
            end
            DRAIN: nxt = d != D_LAST ? DRAIN : kij == K_LAST ? WAIT_PS : LOAD_W;
            WAIT_PS: nxt = psum_cnt == P_MAX ? DONE : WAIT_PS;
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        inst_d = inst_idle();
        inst_d[INST_CEN0] = ~issue;
        inst_d[INST_A0 +: 8] = issue ? addr : 8'h00;
        inst_d[INST_OFIFO_RD] = wr;
        inst_d[INST_CEN_PMEM] = ~wr;
        inst_d[INST_WEN_PMEM] = ~wr;
        inst_d[INST_A_PMEM +: 9] = wr ? psum_cnt : 9'h000;
        inst_d[INST_L0_WR] = ~inst_q[INST_CEN0];
        inst_d[INST_L0_RD] = inst_q[INST_L0_WR];
        inst_d[INST_LOAD +: 3] = ctrl;
    end

    ws_ctrl_dly #(.DEPTH(CTRL_DLY)) u_dly (
        .clk  (clk),
        .reset(reset),
        .din  (tag),
        .dout (ctrl)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            t <= 8'h00;
            n <= 8'h00;
            d <= 8'h00;
            kij <= 4'h0;
            psum_cnt <= 9'h000;
            inst_q <= inst_idle();
        end else begin
            state <= nxt;
            t <= state == LOAD_W ? t + 8'(issue) : 8'h00;
            n <= state == EXEC ? n + 8'(issue) : 8'h00;
            d <= state == DRAIN ? d + 8'h01 : 8'h00;
            kij <= accept ? 4'h0 : kij + 4'(state == DRAIN && d == D_LAST);
            psum_cnt <= accept ? 9'h000 : psum_cnt + 9'(wr && psum_cnt != P_MAX);
            inst_q <= inst_d;
        end
    end

`ifdef WS_SEQ_PERF_EN
    logic [15:0] stall_q;
    always_ff @(posedge clk) begin
        if (!reset || accept) stall_q <= 16'h0000;
        else if ((state == LOAD_W || state == EXEC) && !bus.l0_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'h0001;
    end
    assign bus.stall_cnt = stall_q;
`endif

    assign bus.inst = inst_q;
    assign bus.busy = state != IDLE;
    assign bus.done = state == DONE;
    assign bus.kij_idx = kij;
endmodule

// File: tb/tb_ws_inst_seq.sv
// tb_ws_inst_seq: directed scoreboard bench for ws_inst_seq (A0 reads and PMEM writes checked by a monitor against queued expectations)
module tb_ws_inst_seq;
    localparam logic [39:0] RST_INST = 40'h30_0403_0000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic ofifo_mod = 1'b0;
    logic ofifo_man = 1'b0;
    bit   ofifo_auto = 1'b1;
    int   checks = 0;
    int   errs = 0;
    int   wr_total = 0;
    int   wr_base = 0;
    int   done_total = 0;
    int   flush_total = 0;
    logic [7:0] exp_a0[$];
    logic [8:0] exp_pm[$];

    always #5 clk = ~clk;

    ws_inst_seq_if bus();
    assign bus.ofifo_valid = ofifo_mod | ofifo_man;

    ws_inst_seq dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_run();
        for (int k = 0; k < 9; k++) begin
            for (int w = 0; w < 8; w++) exp_a0.push_back(8'h80 + 8'(8 * k + w));
            exp_a0.push_back(8'h00);
            exp_a0.push_back(8'h01);
        end
        for (int p = 0; p < 18; p++) exp_pm.push_back(9'(p));
        wr_base = wr_total;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        int i;
        i = 0;
        while (!bus.done && i < 3000) begin
            @(negedge clk);
            i++;
        end
        chk("done_reached", 64'(i < 3000), 1);
        @(negedge clk);
        chk("done_one_cycle", bus.done, 0);
        chk("idle_busy", bus.busy, 0);
        chk("idle_inst", bus.inst, RST_INST);
    endtask

    initial forever begin
        @(negedge clk);
        if (reset) begin
            if (!bus.inst[17]) begin
                if (exp_a0.size() == 0) chk("a0_unexpected_read", {1'b1, bus.inst[15:8]}, 0);
                else chk("a0_addr", bus.inst[15:8], exp_a0.pop_front());
            end
            if (!bus.inst[37]) begin
                wr_total++;
                chk("pmem_ctl", {bus.inst[36], bus.inst[7]}, 2'b01);
                if (exp_pm.size() == 0) chk("pmem_unexpected_write", {1'b1, bus.inst[35:27]}, 0);
                else chk("pmem_addr", bus.inst[35:27], exp_pm.pop_front());
            end
            if (bus.inst[2:0] == 3'b111) flush_total++;
            if (bus.done) begin
                done_total++;
                chk("done_wr_cnt", 64'(wr_total - wr_base), 18);
                chk("done_queues_empty", 64'(exp_a0.size() + exp_pm.size()), 0);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (ofifo_auto && bus.inst[2:0] == 3'b111) begin
            ofifo_mod = 1'b1;
            repeat (2) @(negedge clk);
            ofifo_mod = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        int f0;
        int d0;
        logic [2:0] ctl_exp [4];
        ctl_exp[0] = 3'b010;
        ctl_exp[1] = 3'b010;
        ctl_exp[2] = 3'b111;
        ctl_exp[3] = 3'b000;
        bus.start = 1'b0;
        bus.l0_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_inst", bus.inst, RST_INST);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_kij", bus.kij_idx, 0);
        reset = 1'b1;
        @(negedge clk);

        push_run();
        f0 = flush_total;
        d0 = done_total;
        pulse_start();
        chk("busy_after_start", bus.busy, 1);
        i = 0;
        while (bus.inst[17] && i < 20) begin
            @(negedge clk);
            i++;
        end
        chk("first_read_seen", 64'(i < 20), 1);
        chk("first_read_ctl", bus.inst[4:0], 5'b00000);
        @(negedge clk);
        chk("l0_wr_lag", bus.inst[4:0], 5'b01000);
        @(negedge clk);
        chk("l0_rd_lag", bus.inst[4:0], 5'b11000);
        @(negedge clk);
        chk("load_lag", bus.inst[4:0], 5'b11001);
        i = 0;
        while (!(!bus.inst[17] && bus.inst[15:8] == 8'h00) && i < 20) begin
            @(negedge clk);
            i++;
        end
        chk("exec_read_seen", 64'(i < 20), 1);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("exec_flush_ctl", bus.inst[2:0], ctl_exp[k]);
            @(negedge clk);
        end
        wait_done();
        chk("flush_cnt", 64'(flush_total - f0), 9);
        chk("done_cnt", 64'(done_total - d0), 1);

        push_run();
        pulse_start();
        i = 0;
        while (!(!bus.inst[17] && bus.inst[15:8] == 8'h82) && i < 20) begin
            @(negedge clk);
            i++;
        end
        chk("bp_read_82_seen", 64'(i < 20), 1);
        bus.l0_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("bp_cen0_high", bus.inst[17], 1);
        end
        bus.l0_ready = 1'b1;
        i = 0;
        while (!(bus.kij_idx == 4'd2 && bus.inst[2:0] == 3'b111) && i < 400) begin
            @(negedge clk);
            i++;
        end
        chk("kij2_flush_seen", 64'(i < 400), 1);
        pulse_start();
        chk("busy_start_kij", bus.kij_idx, 2);
        chk("busy_start_busy", bus.busy, 1);
        i = 0;
        while (bus.kij_idx == 4'd2 && i < 40) begin
            @(negedge clk);
            i++;
        end
        chk("busy_start_kij_next", bus.kij_idx, 3);
        wait_done();
`ifdef WS_SEQ_PERF_EN
        chk("stall_cnt", bus.stall_cnt, 4);
`endif

        push_run();
        pulse_start();
        i = 0;
        while (!(bus.kij_idx == 4'd4 && !bus.inst[17] && bus.inst[15:8] == 8'h00) && i < 400) begin
            @(negedge clk);
            i++;
        end
        chk("kij4_exec_seen", 64'(i < 400), 1);
        #1;
        reset = 1'b0;
        exp_a0.delete();
        exp_pm.delete();
        @(negedge clk);
        chk("mid_rst_inst", bus.inst, RST_INST);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_kij", bus.kij_idx, 0);
        chk("mid_rst_done", bus.done, 0);
        reset = 1'b1;
        @(negedge clk);

        ofifo_auto = 1'b0;
        push_run();
        d0 = done_total;
        pulse_start();
        i = 0;
        while (bus.inst[17] && i < 20) begin
            @(negedge clk);
            i++;
        end
        chk("replay_first_addr", bus.inst[15:8], 8'h80);
        i = 0;
        while (bus.kij_idx != 4'd9 && i < 400) begin
            @(negedge clk);
            i++;
        end
        chk("wait_ps_reached", 64'(i < 400), 1);
        repeat (5) begin
            @(negedge clk);
            chk("wait_ps_busy_done", {bus.busy, bus.done}, 2'b10);
        end
        ofifo_man = 1'b1;
        repeat (18) @(negedge clk);
        ofifo_man = 1'b0;
        wait_done();
        chk("late_done_cnt", 64'(done_total - d0), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end
endmodule
